hsem_task_disp: RTL

Core-side dispatcher for the semaphore task register. It watches the task-status word produced by the AHB-writable task register and latches every newly raised bit as a pending task. It offers pending tasks to the core one at a time, in round-robin order, over a valid/ready handshake, then tracks completion or timeout. Completion and error bitmaps are returned to the AHB side, which clears them write-1-to-clear.

---
 rtl/hsem_task_disp_pkg.sv | 28 ++
 rtl/hsem_task_disp_if.sv | 41 ++++
 rtl/hsem_rr_pick.sv | 29 ++
 rtl/hsem_task_disp.sv | 136 +++++++++++++
 4 files changed

// File: rtl/hsem_task_disp_pkg.sv
// hsem_task_disp shared types and defaults.
// Imported by the interface, the picker and the top.
`ifndef TASK_SWITCH_WIDTH
`define TASK_SWITCH_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH `TASK_SWITCH_WIDTH
`endif

package hsem_task_disp_pkg;

  localparam int TSW_DEF = `TASK_SWITCH_WIDTH;
  localparam int DW_DEF  = `AHB_DATA_WIDTH;
  localparam int TID_DEF = $clog2(TSW_DEF);
  localparam int TMO_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Round-robin scan origin: one past the last served id.
  function automatic int rr_next(input int last, input int w);
    return (last + 1) % w;
  endfunction

endpackage

// File: rtl/hsem_task_disp_if.sv
// hsem_task_disp bus bundle: task word, W1C path,
// core offer handshake and status bitmaps.
interface hsem_task_disp_if
  import hsem_task_disp_pkg::*;
#(
  parameter int TSW = TSW_DEF,
  parameter int TID = TID_DEF,
  parameter int DW  = DW_DEF
);

  logic [TSW-1:0] tsk_stat;
  logic           wr_en;
  logic           done_clr_en;
  logic           err_clr_en;
  logic [DW-1:0]  ihwdata;
  logic           core_req_vld;
  logic [TID-1:0] core_req_id;
  logic           core_req_rdy;
  logic           core_done;
  logic           busy;
  logic [TSW-1:0] pend_stat;
  logic [TSW-1:0] done_stat;
  logic [TSW-1:0] err_stat;

  modport master (
    output tsk_stat, wr_en, done_clr_en,
    output err_clr_en, ihwdata,
    output core_req_rdy, core_done,
    input  core_req_vld, core_req_id, busy,
    input  pend_stat, done_stat, err_stat
  );

  modport slave (
    input  tsk_stat, wr_en, done_clr_en,
    input  err_clr_en, ihwdata,
    input  core_req_rdy, core_done,
    output core_req_vld, core_req_id, busy,
    output pend_stat, done_stat, err_stat
  );

endinterface

// File: rtl/hsem_rr_pick.sv
// Combinational round-robin first-set finder.
// Scans upward from i_start with wrap-around.
module hsem_rr_pick #(
  parameter int W   = 32,
  parameter int IDW = 5
) (
  input  logic [W-1:0]   i_req,
  input  logic [IDW-1:0] i_start,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  logic [IDW-1:0] w_k;

  // Walk offsets from far to near so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_k = IDW'((int'(i_start) + i) % W);
      if (i_req[w_k]) begin
        o_found = 1'b1;
        o_idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/hsem_task_disp.sv
// Semaphore task dispatcher: latches task rises,
// offers them round-robin, tracks done/timeout.
module hsem_task_disp
  import hsem_task_disp_pkg::*;
#(
  parameter int TASK_SWITCH_WIDTH = TSW_DEF,
  parameter int TASK_ID_WIDTH     = $clog2(TASK_SWITCH_WIDTH),
  parameter int AHB_DATA_WIDTH    = TASK_SWITCH_WIDTH,
  parameter int TIMEOUT_CYCLES    = TMO_DEF
) (
  input logic             hclk,
  input logic             hresetn,
  hsem_task_disp_if.slave bus
);

  localparam int W   = TASK_SWITCH_WIDTH;
  localparam int IDW = TASK_ID_WIDTH;
  localparam logic [15:0] TMAX =
    16'(TIMEOUT_CYCLES - 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [W-1:0]   r_tsk_q;
  logic [W-1:0]   r_pend;
  logic [W-1:0]   r_done;
  logic [W-1:0]   r_err;
  logic [IDW-1:0] r_cur_id;
  logic [IDW-1:0] r_last_id;
  logic [15:0]    r_timer;

  logic [W-1:0]   w_rise;
  logic [W-1:0]   w_pend_clr;
  logic [W-1:0]   w_done_set;
  logic [W-1:0]   w_err_set;
  logic [W-1:0]   w_done_clr;
  logic [W-1:0]   w_err_clr;
  logic [W-1:0]   w_pend_nxt;
  logic [W-1:0]   w_done_nxt;
  logic [W-1:0]   w_err_nxt;
  logic [IDW-1:0] w_cur_nxt;
  logic [IDW-1:0] w_last_nxt;
  logic [15:0]    w_timer_nxt;
  logic [IDW-1:0] w_start;
  logic           w_pick_vld;
  logic [IDW-1:0] w_pick_id;

  assign w_rise  = bus.tsk_stat & ~r_tsk_q;
  assign w_start = IDW'(rr_next(int'(r_last_id), W));

  hsem_rr_pick #(
    .W   (W),
    .IDW (IDW)
  ) u_pick (
    .i_req   (r_pend),
    .i_start (w_start),
    .o_found (w_pick_vld),
    .o_idx   (w_pick_id)
  );

  // Next-state and bitmap update decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_id;
    w_last_nxt  = r_last_id;
    w_timer_nxt = r_timer;
    w_pend_clr  = '0;
    w_done_set  = '0;
    w_err_set   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_cur_nxt   = w_pick_id;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.core_req_rdy) begin
          w_pend_clr[r_cur_id] = 1'b1;
          w_last_nxt  = r_cur_id;
          w_timer_nxt = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_timer_nxt = r_timer + 16'd1;
        if (bus.core_done) begin
          w_done_set[r_cur_id] = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == TMAX) begin
          w_err_set[r_cur_id] = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_done_clr = (bus.wr_en && bus.done_clr_en)
               ? bus.ihwdata : '0;
    w_err_clr  = (bus.wr_en && bus.err_clr_en)
               ? bus.ihwdata : '0;
    // Sets are ORed last so they beat clears.
    w_pend_nxt = (r_pend & ~w_pend_clr) | w_rise;
    w_done_nxt = (r_done & ~w_done_clr) | w_done_set;
    w_err_nxt  = (r_err & ~w_err_clr) | w_err_set;
  end

  // State and bitmap registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= ST_IDLE;
      r_tsk_q   <= '0;
      r_pend    <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_cur_id  <= '0;
      r_last_id <= IDW'(W - 1);
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tsk_q   <= bus.tsk_stat;
      r_pend    <= w_pend_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_cur_id  <= w_cur_nxt;
      r_last_id <= w_last_nxt;
      r_timer   <= w_timer_nxt;
    end
  end

  assign bus.core_req_vld = (r_state == ST_OFFER);
  assign bus.core_req_id  = r_cur_id;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.pend_stat    = r_pend;
  assign bus.done_stat    = r_done;
  assign bus.err_stat     = r_err;

endmodule
